axil_regfile: RTL and testbench
===============================

Name: axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed-width AXI4-Lite slave port set used in the integration samples.
- Provides NUM_REGS registers of DATA_WIDTH bits with byte write strobes, per-register read-only masking, SLVERR on bad accesses, and per-register write pulses.
- Sits between an interconnect master port and core control/status logic.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 16, register count; power of two, 2..256.
- RO_MASK, '0 (NUM_REGS bits), bit i=1 makes register i read-only; it reads reg_in slice i.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1 / s_axi_awready  out  1  AW handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s_axi_wvalid  in  1 / s_axi_wready  out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1 / s_axi_bready  in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1 / s_axi_arready  out  1  AR handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1 / s_axi_rready  in  1  R handshake
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened RW register contents; RO slices drive 0
- reg_in  in  NUM_REGS*DATA_WIDTH  status values for RO registers
- wr_pulse  out  NUM_REGS  one-cycle pulse per successful write

Behaviour:
- Reset (rst=1, async): all registers 0; awready, wready, arready, bvalid, rvalid, wr_pulse = 0; bresp, rresp, rdata = 0. Readies assert in the first cycle after rst falls.
- Decode: OFS = log2(DATA_WIDTH/8), IW = log2(NUM_REGS). idx = addr[OFS +: IW]. Out of range if any addr bit at position >= OFS+IW is set. Low OFS bits are ignored.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, awready and wready are independent. AW and W may arrive in either order or in the same cycle. Each is latched once and its ready drops after its handshake.
  - When both are held, the commit occurs at that clock edge and the FSM enters W_RESP.
  - Commit on a valid RW idx: byte k of the register is updated only where wstrb[k]=1; wr_pulse[idx]=1 for exactly the next cycle; bresp=OKAY (00).
  - Commit on an out-of-range or RO idx: no state change, no pulse, bresp=SLVERR (10).
  - In W_RESP, bvalid=1 and is held stable until bready. On handshake, return to W_IDLE with both readies at 1 the next cycle.
  - Throughput: one write per 2 cycles minimum.
- Read FSM, states R_IDLE, R_DATA:
  - In R_IDLE, arready=1. On the AR handshake, rdata is captured at that edge: register value, or reg_in slice for RO. rresp=OKAY, or SLVERR with rdata=0 when out of range.
  - In R_DATA, rvalid=1 and rdata/rresp are held until rready, then return to R_IDLE.
  - Read latency: 1 cycle from AR handshake to rvalid.
- Simultaneous read and write commit to the same register in one cycle: the read returns the pre-write value.
- Read and write channels are fully independent; neither stalls the other.
- wstrb=0 on a valid RW address: OKAY response, no data change, and wr_pulse still fires.
- rst asserted mid-transaction: any in-flight response is dropped, both FSMs return to IDLE, and registers clear.

Decomposition:
- Package axil_pkg: resp_t enum (OKAY=2'b00, SLVERR=2'b10), w_state_t and r_state_t enums, and an address-decode function returning idx plus an out-of-range flag.
- One sub-module, axil_regfile_core: register array with byte-strobe write port, combinational read mux, and RO/reg_in selection.
- The AXI FSMs live in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x08 (wstrb=0xF) -> bresp=00, wr_pulse[2] high for 1 cycle, read 0x08 returns 0xDEADBEEF with rresp=00 and rvalid 1 cycle after AR.
- W presented 3 cycles before AW, then AW; write 0x0 to 0x04 with wstrb=0x2 over prior 0x11223344 -> register reads 0x11220044.
- Write to 0x40 with NUM_REGS=16 -> bresp=10, all registers unchanged; read 0x40 -> rresp=10, rdata=0.
- RO_MASK bit 3 set, reg_in slice 3=0xA5A5A5A5: write 0x0C -> SLVERR and no pulse; read 0x0C -> 0xA5A5A5A5, OKAY.
- Hold bready=0 and rready=0 for 5 cycles with responses pending -> bvalid/rvalid, bresp/rresp and rdata stable; awready and arready stay 0.
- Same-cycle write commit of 0x1 and AR to 0x00 holding 0x0 -> read returns 0x0, a subsequent read returns 0x1. Assert rst during W_RESP -> bvalid=0 immediately and registers read 0 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and address decode for the AXI4-Lite register file.
package axil_pkg;

   localparam int unsigned MaxAddrW = 64;
   localparam int unsigned MaxIdxW  = 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {WIdle, WResp} w_state_t;
   typedef enum logic {RIdle, RData} r_state_t;

   typedef struct packed {
      logic [MaxIdxW-1:0] idx;
      logic               oor;
   } dec_t;

   // Byte address -> register index; any bit above the index field flags out-of-range.
   function automatic dec_t axil_decode(input logic [MaxAddrW-1:0] addr,
                                        input int unsigned ofs,
                                        input int unsigned iw);
      dec_t d;
      logic [MaxAddrW-1:0] sh;
      sh    = addr >> ofs;
      d.idx = MaxIdxW'(sh & ((MaxAddrW'(1) << iw) - MaxAddrW'(1)));
      d.oor = |(sh >> iw);
      return d;
   endfunction

endpackage

// File: rtl/axil_regfile_core.sv
// Register array with byte-strobe write port and combinational read mux.
// Read-only slots read from reg_in_i and drive zero on reg_out_o.
module axil_regfile_core
   import axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we_i,
   input  logic [$clog2(NUM_REGS)-1:0]    widx_i,
   input  logic [DATA_WIDTH-1:0]          wdata_i,
   input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
   input  logic [$clog2(NUM_REGS)-1:0]    ridx_i,
   output logic [DATA_WIDTH-1:0]          rdata_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out_o
);

   localparam int unsigned StrbW = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   // Next-state: merge strobed bytes into the addressed RW register.
   always_comb begin
      regs_d = regs_q;
      if (we_i && !RO_MASK[widx_i]) begin
         for (int k = 0; k < StrbW; k++) begin
            if (wstrb_i[k]) regs_d[widx_i][8*k +: 8] = wdata_i[8*k +: 8];
         end
      end
   end

   // Register storage, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read mux: RO slots return the live status input.
   always_comb begin
      if (RO_MASK[ridx_i]) rdata_o = reg_in_i[32'(ridx_i) * DATA_WIDTH +: DATA_WIDTH];
      else                 rdata_o = regs_q[ridx_i];
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign reg_out_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
   end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file: independent write and read FSMs around the core array.
module axil_regfile
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                     s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
   output logic [NUM_REGS-1:0]            wr_pulse
);

   localparam int unsigned StrbW = DATA_WIDTH / 8;
   localparam int unsigned Ofs   = $clog2(StrbW);
   localparam int unsigned Iw    = $clog2(NUM_REGS);

   w_state_t w_state_q, w_state_d;
   r_state_t r_state_q, r_state_d;
   logic                  rdy_en_q;
   logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [StrbW-1:0]      wstrb_q, wstrb_d;
   resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

   logic                  aw_hs, w_hs, ar_hs, commit, w_ok;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data, core_rdata;
   logic [StrbW-1:0]      w_strb;
   dec_t                  w_dec, r_dec;
   logic [Iw-1:0]         w_idx, r_idx;

   // Channel handshakes; a transfer is either already latched or completing this cycle.
   assign aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_hs   = s_axi_wvalid && s_axi_wready;
   assign ar_hs  = s_axi_arvalid && s_axi_arready;
   assign w_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
   assign w_data = w_held_q ? wdata_q : s_axi_wdata;
   assign w_strb = w_held_q ? wstrb_q : s_axi_wstrb;
   assign commit = (w_state_q == WIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

   assign w_dec = axil_decode(MaxAddrW'(w_addr), Ofs, Iw);
   assign r_dec = axil_decode(MaxAddrW'(s_axi_araddr), Ofs, Iw);
   assign w_idx = Iw'(w_dec.idx);
   assign r_idx = Iw'(r_dec.idx);
   assign w_ok  = !w_dec.oor && !RO_MASK[w_idx];

   axil_regfile_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .RO_MASK    (RO_MASK)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .we_i      (commit && w_ok),
      .widx_i    (w_idx),
      .wdata_i   (w_data),
      .wstrb_i   (w_strb),
      .ridx_i    (r_idx),
      .rdata_o   (core_rdata),
      .reg_in_i  (reg_in),
      .reg_out_o (reg_out)
   );

   // Write FSM state register; rdy_en_q holds readies low until the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q  <= WIdle;
         rdy_en_q   <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= OKAY;
         wr_pulse_q <= '0;
      end else begin
         w_state_q  <= w_state_d;
         rdy_en_q   <= 1'b1;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   // Write FSM next state: latch AW/W independently, commit once both are present.
   always_comb begin
      w_state_d  = w_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      case (w_state_q)
         WIdle: begin
            if (commit) begin
               w_state_d = WResp;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = w_ok ? OKAY : SLVERR;
               if (w_ok) wr_pulse_d = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_idx;
            end else begin
               if (aw_hs) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = s_axi_awaddr;
               end
               if (w_hs) begin
                  w_held_d = 1'b1;
                  wdata_d  = s_axi_wdata;
                  wstrb_d  = s_axi_wstrb;
               end
            end
         end
         WResp:   if (s_axi_bready) w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   // Write channel outputs.
   always_comb begin
      s_axi_awready = rdy_en_q && (w_state_q == WIdle) && !aw_held_q;
      s_axi_wready  = rdy_en_q && (w_state_q == WIdle) && !w_held_q;
      s_axi_bvalid  = (w_state_q == WResp);
      s_axi_bresp   = bresp_q;
      wr_pulse      = wr_pulse_q;
   end

   // Read FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= RIdle;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Read FSM next state: capture data at AR handshake (pre-write value on a same-cycle commit).
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         RIdle: begin
            if (ar_hs) begin
               r_state_d = RData;
               rdata_d   = r_dec.oor ? '0 : core_rdata;
               rresp_d   = r_dec.oor ? SLVERR : OKAY;
            end
         end
         RData:   if (s_axi_rready) r_state_d = RIdle;
         default: r_state_d = RIdle;
      endcase
   end

   // Read channel outputs.
   always_comb begin
      s_axi_arready = rdy_en_q && (r_state_q == RIdle);
      s_axi_rvalid  = (r_state_q == RData);
      s_axi_rdata   = rdata_q;
      s_axi_rresp   = rresp_q;
   end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile (32-bit data, 16 registers, register 3 read-only).
module tb_axil_regfile;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;
   localparam logic [NR-1:0] RoMask = 16'h0008;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
   logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
   logic s_axi_bready = 1'b1, s_axi_rready = 1'b1;
   logic [DW-1:0] s_axi_wdata = '0;
   logic [DW/8-1:0] s_axi_wstrb = '0;
   logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
   logic [1:0] s_axi_bresp, s_axi_rresp;
   logic [DW-1:0] s_axi_rdata;
   logic [NR*DW-1:0] reg_out, reg_in;
   logic [NR-1:0] wr_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axil_regfile #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .RO_MASK    (RoMask)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .reg_out       (reg_out),
      .reg_in        (reg_in),
      .wr_pulse      (wr_pulse)
   );

   // Full write transaction; returns response and the pulse vector seen with bvalid.
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [NR-1:0] pulse);
      logic aw_pend, w_pend, aw_fire, w_fire;
      int n;
      s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      aw_pend = 1'b1; w_pend = 1'b1; n = 0;
      while ((aw_pend || w_pend) && n < 20) begin
         aw_fire = aw_pend && s_axi_awready;
         w_fire  = w_pend && s_axi_wready;
         @(posedge clk); #1; n++;
         if (aw_fire) begin aw_pend = 1'b0; s_axi_awvalid = 1'b0; end
         if (w_fire)  begin w_pend = 1'b0; s_axi_wvalid = 1'b0; end
      end
      n = 0;
      while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (!s_axi_bvalid) begin
         errors++;
         $display("FAIL write_timeout addr %h: bvalid %b required 1", addr, s_axi_bvalid);
      end
      resp = s_axi_bresp; pulse = wr_pulse;
      @(posedge clk); #1;
   endtask

   // Full read transaction; lat1 reports rvalid on the first sample after the AR handshake.
   task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp, output logic lat1);
      int n;
      s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1; n = 0;
      while (!s_axi_arready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      lat1 = s_axi_rvalid;
      n = 0;
      while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (!s_axi_rvalid) begin
         errors++;
         $display("FAIL read_timeout addr %h: rvalid %b required 1", addr, s_axi_rvalid);
      end
      data = s_axi_rdata; resp = s_axi_rresp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_readies: got %b required 000",
                  {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      checks++;
      if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse} !== '0)
      begin
         errors++;
         $display("FAIL reset_outputs: bv %b rv %b br %b rr %b rd %h pulse %h required all 0",
                  s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse);
      end
      checks++;
      if (reg_out !== '0) begin
         errors++;
         $display("FAIL reset_reg_out: got %h required 0", reg_out);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_release_readies: got %b required 111",
                  {s_axi_awready, s_axi_wready, s_axi_arready});
      end
   endtask

   task automatic test_basic();
      logic [1:0] resp; logic [NR-1:0] pulse; logic [DW-1:0] data; logic lat1;
      do_write(32'h08, 32'hDEADBEEF, 4'hF, resp, pulse);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL basic_bresp: got %b required 00", resp); end
      checks++;
      if (pulse !== 16'h0004) begin
         errors++; $display("FAIL basic_pulse: got %h required 0004", pulse);
      end
      checks++;
      if (wr_pulse !== '0) begin
         errors++; $display("FAIL basic_pulse_width: got %h required 0000", wr_pulse);
      end
      checks++;
      if (reg_out[2*DW +: DW] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL basic_reg_out: got %h required deadbeef", reg_out[2*DW +: DW]);
      end
      do_read(32'h08, data, resp, lat1);
      checks++;
      if ({lat1, resp, data} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL basic_read: lat1 %b resp %b data %h required 1 00 deadbeef",
                  lat1, resp, data);
      end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; logic [NR-1:0] pulse; logic [DW-1:0] data; logic lat1;
      do_write(32'h04, 32'h11223344, 4'hF, resp, pulse);
      s_axi_wdata = 32'h0; s_axi_wstrb = 4'h2; s_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
      checks++;
      if ({s_axi_wready, s_axi_awready, s_axi_bvalid} !== 3'b010) begin
         errors++;
         $display("FAIL wfirst_held: wready %b awready %b bvalid %b required 0 1 0",
                  s_axi_wready, s_axi_awready, s_axi_bvalid);
      end
      repeat (2) @(posedge clk);
      #1;
      s_axi_awaddr = 32'h04; s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      checks++;
      if ({s_axi_bvalid, s_axi_bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0002}) begin
         errors++;
         $display("FAIL wfirst_commit: bvalid %b bresp %b pulse %h required 1 00 0002",
                  s_axi_bvalid, s_axi_bresp, wr_pulse);
      end
      @(posedge clk); #1;
      do_read(32'h04, data, resp, lat1);
      checks++;
      if (data !== 32'h11220044) begin
         errors++; $display("FAIL wfirst_data: got %h required 11220044", data);
      end
   endtask

   task automatic test_oor_ro();
      logic [1:0] resp; logic [NR-1:0] pulse; logic [DW-1:0] data; logic lat1;
      logic [NR*DW-1:0] snap;
      snap = '0;
      snap[1*DW +: DW] = 32'h11220044;
      snap[2*DW +: DW] = 32'hDEADBEEF;
      do_write(32'h40, 32'hFFFFFFFF, 4'hF, resp, pulse);
      checks++;
      if ({resp, pulse} !== {2'b10, 16'h0000}) begin
         errors++; $display("FAIL oor_write: resp %b pulse %h required 10 0000", resp, pulse);
      end
      checks++;
      if (reg_out !== snap) begin
         errors++; $display("FAIL oor_unchanged: got %h required %h", reg_out, snap);
      end
      do_read(32'h40, data, resp, lat1);
      checks++;
      if ({resp, data} !== {2'b10, 32'h0}) begin
         errors++; $display("FAIL oor_read: resp %b data %h required 10 0", resp, data);
      end
      do_write(32'h0C, 32'h12345678, 4'hF, resp, pulse);
      checks++;
      if ({resp, pulse} !== {2'b10, 16'h0000}) begin
         errors++; $display("FAIL ro_write: resp %b pulse %h required 10 0000", resp, pulse);
      end
      do_read(32'h0C, data, resp, lat1);
      checks++;
      if ({resp, data} !== {2'b00, 32'hA5A5A5A5}) begin
         errors++; $display("FAIL ro_read: resp %b data %h required 00 a5a5a5a5", resp, data);
      end
      do_write(32'h08, 32'h00000000, 4'h0, resp, pulse);
      checks++;
      if ({resp, pulse, reg_out} !== {2'b00, 16'h0004, snap}) begin
         errors++;
         $display("FAIL zero_strb: resp %b pulse %h reg_out %h required 00 0004 %h",
                  resp, pulse, reg_out, snap);
      end
   endtask

   task automatic test_backpressure();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      s_axi_awaddr = 32'h10; s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF;
      s_axi_araddr = 32'h08;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata,
              s_axi_awready, s_axi_wready, s_axi_arready}
             !== {1'b1, 1'b1, 2'b00, 2'b00, 32'hDEADBEEF, 3'b000}) begin
            errors++;
            $display("FAIL stall_cycle%0d: bv %b rv %b br %b rr %b rd %h rdy %b%b%b req 1 1 00 00 deadbeef 000",
                     c, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata,
                     s_axi_awready, s_axi_wready, s_axi_arready);
         end
         @(posedge clk); #1;
      end
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 5'b00111)
      begin
         errors++;
         $display("FAIL stall_release: bv %b rv %b rdy %b%b%b required 0 0 111",
                  s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_arready);
      end
   endtask

   task automatic test_same_cycle();
      logic [1:0] resp; logic [DW-1:0] data; logic lat1;
      s_axi_awaddr = 32'h00; s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h00;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      checks++;
      if ({s_axi_bvalid, s_axi_rvalid, s_axi_rdata} !== {1'b1, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL same_cycle_old: bv %b rv %b rdata %h required 1 1 0",
                  s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
      end
      @(posedge clk); #1;
      do_read(32'h00, data, resp, lat1);
      checks++;
      if (data !== 32'h1) begin
         errors++; $display("FAIL same_cycle_new: got %h required 1", data);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [DW-1:0] data; logic lat1;
      s_axi_bready = 1'b0;
      s_axi_awaddr = 32'h18; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      checks++;
      if (s_axi_bvalid !== 1'b1) begin
         errors++; $display("FAIL midrst_pending: bvalid %b required 1", s_axi_bvalid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({s_axi_bvalid, reg_out} !== {1'b0, {(NR*DW){1'b0}}}) begin
         errors++;
         $display("FAIL midrst_async: bvalid %b reg_out %h required 0 0", s_axi_bvalid, reg_out);
      end
      @(posedge clk); #1;
      rst = 1'b0; s_axi_bready = 1'b1;
      @(posedge clk); #1;
      do_read(32'h08, data, resp, lat1);
      checks++;
      if ({resp, data} !== {2'b00, 32'h0}) begin
         errors++; $display("FAIL midrst_clear8: resp %b data %h required 00 0", resp, data);
      end
      do_read(32'h18, data, resp, lat1);
      checks++;
      if (data !== 32'h0) begin
         errors++; $display("FAIL midrst_clear18: got %h required 0", data);
      end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = 32'hFFFF0000 | 32'(i);
      reg_in[3*DW +: DW] = 32'hA5A5A5A5;
      test_reset();
      test_basic();
      test_w_before_aw();
      test_oor_ro();
      test_backpressure();
      test_same_cycle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
